// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ADD3_THRESH = 4'd5;

  // Elaboration-time power of ten, used for the overflow limit.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 when the nibble is 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t i_nib,
  output bcd_digit_t o_nib
);

  assign o_nib = (i_nib >= BCD_ADD3_THRESH) ? i_nib + 4'd3 : i_nib;

endmodule

// File: rtl/bin2bcd_converter.sv
// Shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional build macro BCD_OVF_SAT_EN: saturate the digits to all nines on overflow.
module bin2bcd_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH = 27,
  parameter int NDIG  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       bin_in,
  output logic                   busy,
  output logic                   done,
  output bcd_digit_t [NDIG-1:0]  digits,
  output logic                   ovf,
  output state_t                 dbg_state
);

  localparam int          CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int          SW        = (NDIG + 1) * 4;
  localparam logic [63:0] OVF_LIMIT = pow10(NDIG);

  // Handshake: start is a request sampled on the rising edge and accepted only
  // in IDLE or DONE (ignored, never queued, in SHIFT); done is a one-cycle
  // pulse during which digits/ovf already show the new result.
  state_t                 r_state;
  state_t                 w_next;
  logic [WIDTH-1:0]       r_bin;
  logic [SW-1:0]          r_scr;
  logic [CW-1:0]          r_cnt;
  logic                   r_ovf_flag;
  bcd_digit_t [NDIG-1:0]  r_digits;
  logic                   r_ovf;

  logic [SW-1:0]          w_scr_adj;
  logic [SW-1:0]          w_scr_nxt;
  logic [WIDTH-1:0]       w_bin_nxt;
  logic                   w_unused_msb;
  logic                   w_accept;
  logic                   w_last;

  genvar g;
  generate
    for (g = 0; g < NDIG + 1; g++) begin : g_add3
      bcd_add3 u_add3 (
        .i_nib (r_scr[g*4 +: 4]),
        .o_nib (w_scr_adj[g*4 +: 4])
      );
    end
  endgenerate

  // The corrected scratch MSB is shifted out; the WIDTH constraint keeps it zero.
  assign {w_unused_msb, w_scr_nxt, w_bin_nxt} = {w_scr_adj, r_bin, 1'b0};

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_state == SHIFT) && (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == SHIFT);
    done      = (r_state == DONE);
    dbg_state = r_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin      <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf_flag <= 1'b0;
    end else if (w_accept) begin
      r_bin      <= bin_in;
      r_scr      <= '0;
      r_cnt      <= CW'(WIDTH - 1);
      r_ovf_flag <= (64'(bin_in) >= OVF_LIMIT);
    end else if (r_state == SHIFT) begin
      r_bin <= w_bin_nxt;
      r_scr <= w_scr_nxt;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Result registers load on the final shift edge so they change with done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digits <= '0;
      r_ovf    <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_ovf_flag;
`ifdef BCD_OVF_SAT_EN
      if (r_ovf_flag) begin
        for (int i = 0; i < NDIG; i++) r_digits[i] <= 4'd9;
      end else begin
        r_digits <= w_scr_nxt[NDIG*4-1:0];
      end
`else
      r_digits <= w_scr_nxt[NDIG*4-1:0];
`endif
    end
  end

  assign digits = r_digits;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Self-checking bench for bin2bcd_converter with a decimal-arithmetic reference model.
module tb_bin2bcd_converter;
  import bcd_pkg::*;

  localparam int WIDTH = 27;
  localparam int NDIG  = 8;
  localparam int LAT   = WIDTH + 1;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [NDIG-1:0][3:0]  digits;
  logic                  ovf;
  state_t                dbg_state;

  int checks;
  int errors;
  logic [31:0] last_dg;
  logic [32:0] exp_q[$];

  bin2bcd_converter #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .digits    (digits),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, digits} from plain decimal arithmetic.
  function automatic logic [32:0] model(input longint unsigned v);
    logic [31:0] d;
    logic o;
    longint unsigned t;
    o = (v >= 64'd100000000);
    t = v;
    for (int i = 0; i < NDIG; i++) begin
      d[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
`ifdef BCD_OVF_SAT_EN
    if (o) d = 32'h99999999;
`endif
    return {o, d};
  endfunction

  // Driver: one start pulse, then watch until done (bounded).
  task automatic do_conv(input logic [WIDTH-1:0] val, input logic [31:0] hold,
                         output int lat, output int bcnt, output logic [31:0] dg,
                         output logic o, output int chg);
    @(negedge clk);
    bin_in = val;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; bcnt = 0; chg = 0; dg = '0; o = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        lat = c; dg = digits; o = ovf;
        break;
      end
      if (busy) bcnt++;
      if (digits !== hold) chg++;
      if (c < 60) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n_done;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, ovf, digits} !== 35'd0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b ovf=%b digits=%h state=%0d, need all 0/IDLE",
               busy, done, ovf, digits, dbg_state);
    end
    bin_in = 27'd12345678;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy_before: busy=%b need 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || dbg_state !== IDLE || digits !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_async: busy=%b state=%0d digits=%h need 0/IDLE/0", busy, dbg_state, digits);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++;
    if (n_done != 0 || digits !== 32'd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done: done_pulses=%0d digits=%h ovf=%b need 0/0/0", n_done, digits, ovf);
    end
    last_dg = 32'd0;
  endtask

  task automatic test_known();
    int lat, bcnt, chg;
    logic [31:0] dg;
    logic o;
    do_conv(27'd12345678, last_dg, lat, bcnt, dg, o, chg);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL known_latency: got %0d need %0d", lat, LAT);
    end
    checks++;
    if (bcnt != WIDTH) begin
      errors++;
      $display("FAIL known_busy_cycles: got %0d need %0d", bcnt, WIDTH);
    end
    checks++;
    if ({o, dg} !== model(64'd12345678)) begin
      errors++;
      $display("FAIL known_result: got ovf=%b digits=%h need %h", o, dg, model(64'd12345678));
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL known_done_pulse: done=%b one cycle later, need 0", done);
    end
    last_dg = model(64'd12345678) & 33'h0FFFFFFFF;
  endtask

  task automatic test_stability();
    int lat, bcnt, chg;
    logic [31:0] dg;
    logic o;
    do_conv(27'd7, last_dg, lat, bcnt, dg, o, chg);
    checks++;
    if (chg != 0) begin
      errors++;
      $display("FAIL stability_hold: digits moved off %h in %0d cycles, need 0", last_dg, chg);
    end
    checks++;
    if (lat != LAT || dg !== 32'h00000007 || o !== 1'b0) begin
      errors++;
      $display("FAIL stability_result: lat=%0d digits=%h ovf=%b need %0d/00000007/0", lat, dg, o, LAT);
    end
    last_dg = 32'h00000007;
  endtask

  task automatic test_boundaries();
    logic [WIDTH-1:0] vals[4];
    int lat, bcnt, chg;
    logic [31:0] dg;
    logic o;
    logic [32:0] e;
    vals[0] = 27'd0;
    vals[1] = 27'd99999999;
    vals[2] = 27'd100000000;
    vals[3] = 27'd134217727;
    foreach (vals[i]) begin
      e = model(64'(vals[i]));
      do_conv(vals[i], last_dg, lat, bcnt, dg, o, chg);
      checks++;
      if ({o, dg} !== e || lat != LAT || chg != 0) begin
        errors++;
        $display("FAIL boundary_%0d: in=%0d got ovf=%b digits=%h lat=%0d chg=%0d need %h lat %0d chg 0",
                 i, vals[i], o, dg, lat, chg, e, LAT);
      end
      last_dg = e[31:0];
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    logic [31:0] dg;
    logic o;
    @(negedge clk);
    bin_in = 27'd4321;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; dg = '0; o = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        lat = c; dg = digits; o = ovf;
        break;
      end
      if (c == 5) begin
        bin_in = 27'd98765;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (c < 60) @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (lat != LAT || {o, dg} !== model(64'd4321)) begin
      errors++;
      $display("FAIL ignore_start: lat=%0d ovf=%b digits=%h need %0d and %h",
               lat, o, dg, LAT, model(64'd4321));
    end
    last_dg = 32'h00004321;
  endtask

  task automatic test_back_to_back();
    int n, t1, t2;
    logic [31:0] d1, d2;
    n = 0; t1 = -1; t2 = -1; d1 = '0; d2 = '0;
    @(negedge clk);
    bin_in = 27'd5;
    start  = 1'b1;
    @(negedge clk);
    bin_in = 27'd42;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        if (n == 0) begin t1 = c; d1 = digits; end
        else begin t2 = c; d2 = digits; end
        n++;
      end
      if (n == 2) break;
      if (n == 1 && c == t1 + 1) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (n != 2 || t1 != LAT || (t2 - t1) != LAT) begin
      errors++;
      $display("FAIL b2b_timing: pulses=%0d first=%0d gap=%0d need 2/%0d/%0d", n, t1, t2 - t1, LAT, LAT);
    end
    checks++;
    if (d1 !== 32'h00000005 || d2 !== 32'h00000042) begin
      errors++;
      $display("FAIL b2b_results: got %h then %h need 00000005 then 00000042", d1, d2);
    end
    last_dg = 32'h00000042;
  endtask

  task automatic test_random();
    int lat, bcnt, chg;
    logic [31:0] dg;
    logic o;
    logic [32:0] e;
    logic [WIDTH-1:0] v;
    for (int k = 0; k < 16; k++) begin
      v = WIDTH'($urandom_range(0, 32'h07FFFFFF));
      if (k % 5 == 4) v = WIDTH'($urandom_range(99999990, 100000010));
      exp_q.push_back(model(64'(v)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_conv(v, last_dg, lat, bcnt, dg, o, chg);
      e = exp_q.pop_front();
      checks++;
      if ({o, dg} !== e || lat != LAT || chg != 0) begin
        errors++;
        $display("FAIL random_%0d: in=%0d got ovf=%b digits=%h lat=%0d chg=%0d need %h lat %0d",
                 k, v, o, dg, lat, chg, e, LAT);
      end
      last_dg = e[31:0];
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_dg = '0;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    test_reset();
    test_known();
    test_stability();
    test_boundaries();
    test_ignore_start();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
